// File: rtl/softex_tcdm_splitter.sv
// ============================================================================
// softex_tcdm_splitter : splits one wide TCDM request into MP narrow bank
//                        requests and reassembles the narrow read responses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module softex_tcdm_splitter #(
    parameter int unsigned MP         = 4,
    parameter int unsigned RESP_DEPTH = 2,
    parameter int unsigned ROW_BYTES  = 8,
    parameter int unsigned IW         = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_req_i,
    output logic             in_gnt_o,
    input  logic [31:0]      in_add_i,
    input  logic             in_wen_i,
    input  logic [MP*8-1:0]  in_be_i,
    input  logic [MP*64-1:0] in_data_i,
    input  logic [IW-1:0]    in_id_i,
    output logic             in_r_valid_o,
    input  logic             in_r_ready_i,
    output logic [MP*64-1:0] in_r_data_o,
    output logic [IW-1:0]    in_r_id_o,
    output logic [MP-1:0]    tcdm_req_o,
    input  logic [MP-1:0]    tcdm_gnt_i,
    output logic [MP*32-1:0] tcdm_add_o,
    output logic [MP-1:0]    tcdm_wen_o,
    output logic [MP*8-1:0]  tcdm_be_o,
    output logic [MP*64-1:0] tcdm_data_o,
    input  logic [MP-1:0]    tcdm_r_valid_i,
    input  logic [MP*64-1:0] tcdm_r_data_i
);

    localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
    localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [MP-1:0] granted_q, granted_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MP-1:0] req_gnt;
    logic          allow;
    logic          cnt_inc;
    logic          rsp_pop;
    logic [MP-1:0] fifo_nempty;
    logic          id_nempty;

    // Credit only gates the first port of a read; a partly granted read must finish.
    assign allow   = ~in_wen_i | (granted_q != '0) | (cnt_q < CW'(RESP_DEPTH));
    assign req_gnt = tcdm_req_o & tcdm_gnt_i;
    assign in_gnt_o = in_req_i & allow & (&(granted_q | req_gnt));
    assign cnt_inc = (granted_q == '0) & in_wen_i & (|req_gnt);
    assign rsp_pop = in_r_valid_o & in_r_ready_i;

    // Narrow side fields are forced to zero while no wide request is pending.
    for (genvar i = 0; i < MP; i++) begin : g_req
        assign tcdm_req_o[i]           = in_req_i & ~granted_q[i] & allow;
        assign tcdm_add_o[i*32 +: 32]  = in_req_i ? (in_add_i + 32'(i * ROW_BYTES)) : '0;
        assign tcdm_wen_o[i]           = in_req_i & in_wen_i;
        assign tcdm_be_o[i*8 +: 8]     = in_req_i ? in_be_i[i*8 +: 8] : '0;
        assign tcdm_data_o[i*64 +: 64] = in_req_i ? in_data_i[i*64 +: 64] : '0;
    end

    always_comb begin
        granted_d = in_gnt_o ? '0 : (granted_q | req_gnt);
        cnt_d     = cnt_q;
        if (cnt_inc && !rsp_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!cnt_inc && rsp_pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            granted_q <= '0;
            cnt_q     <= '0;
        end else begin
            granted_q <= granted_d;
            cnt_q     <= cnt_d;
        end
    end

    for (genvar i = 0; i < MP; i++) begin : g_rsp_fifo
        logic [63:0]   mem_q [RESP_DEPTH];
        logic [63:0]   mem_d [RESP_DEPTH];
        logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
        logic [CW-1:0] fill_q, fill_d;
        logic          push;

        assign push = tcdm_r_valid_i[i];

        always_comb begin
            mem_d  = mem_q;
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            fill_d = fill_q;
            if (push) begin
                mem_d[wptr_q] = tcdm_r_data_i[i*64 +: 64];
                wptr_d        = ptr_inc(wptr_q);
            end
            if (rsp_pop) begin
                rptr_d = ptr_inc(rptr_q);
            end
            if (push && !rsp_pop) begin
                fill_d = fill_q + CW'(1);
            end else if (!push && rsp_pop) begin
                fill_d = fill_q - CW'(1);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int k = 0; k < RESP_DEPTH; k++) begin
                    mem_q[k] <= '0;
                end
                wptr_q <= '0;
                rptr_q <= '0;
                fill_q <= '0;
            end else begin
                mem_q  <= mem_d;
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                fill_q <= fill_d;
            end
        end

        assign fifo_nempty[i]          = (fill_q != '0);
        assign in_r_data_o[i*64 +: 64] = mem_q[rptr_q];

`ifndef SYNTHESIS
        always_ff @(posedge clk_i) begin
            if (rst_ni) begin
                assert (!(push && (fill_q == CW'(RESP_DEPTH)) && !rsp_pop))
                    else $error("response fifo %0d overflow", i);
            end
        end
`endif
    end

    logic [IW-1:0] id_mem_q [RESP_DEPTH];
    logic [IW-1:0] id_mem_d [RESP_DEPTH];
    logic [PW-1:0] id_wptr_q, id_wptr_d, id_rptr_q, id_rptr_d;
    logic [CW-1:0] id_fill_q, id_fill_d;
    logic          id_push;

    assign id_push = in_gnt_o & in_wen_i;

    always_comb begin
        id_mem_d  = id_mem_q;
        id_wptr_d = id_wptr_q;
        id_rptr_d = id_rptr_q;
        id_fill_d = id_fill_q;
        if (id_push) begin
            id_mem_d[id_wptr_q] = in_id_i;
            id_wptr_d           = ptr_inc(id_wptr_q);
        end
        if (rsp_pop) begin
            id_rptr_d = ptr_inc(id_rptr_q);
        end
        if (id_push && !rsp_pop) begin
            id_fill_d = id_fill_q + CW'(1);
        end else if (!id_push && rsp_pop) begin
            id_fill_d = id_fill_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < RESP_DEPTH; k++) begin
                id_mem_q[k] <= '0;
            end
            id_wptr_q <= '0;
            id_rptr_q <= '0;
            id_fill_q <= '0;
        end else begin
            id_mem_q  <= id_mem_d;
            id_wptr_q <= id_wptr_d;
            id_rptr_q <= id_rptr_d;
            id_fill_q <= id_fill_d;
        end
    end

    assign id_nempty    = (id_fill_q != '0);
    assign in_r_id_o    = id_mem_q[id_rptr_q];
    assign in_r_valid_o = (&fifo_nempty) & id_nempty;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(id_push && (id_fill_q == CW'(RESP_DEPTH)) && !rsp_pop))
                else $error("id fifo overflow");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_softex_tcdm_splitter.sv
// ============================================================================
// tb_softex_tcdm_splitter : directed bench with a response scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_softex_tcdm_splitter;

    localparam int MP = 4;
    localparam int IW = 8;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             in_req_i;
    logic             in_gnt_o;
    logic [31:0]      in_add_i;
    logic             in_wen_i;
    logic [MP*8-1:0]  in_be_i;
    logic [MP*64-1:0] in_data_i;
    logic [IW-1:0]    in_id_i;
    logic             in_r_valid_o;
    logic             in_r_ready_i;
    logic [MP*64-1:0] in_r_data_o;
    logic [IW-1:0]    in_r_id_o;
    logic [MP-1:0]    tcdm_req_o;
    logic [MP-1:0]    tcdm_gnt_i;
    logic [MP*32-1:0] tcdm_add_o;
    logic [MP-1:0]    tcdm_wen_o;
    logic [MP*8-1:0]  tcdm_be_o;
    logic [MP*64-1:0] tcdm_data_o;
    logic [MP-1:0]    tcdm_r_valid_i;
    logic [MP*64-1:0] tcdm_r_data_i;

    int n_cmp = 0;
    int n_err = 0;

    logic [IW-1:0]    sb_id   [$];
    logic [MP*64-1:0] sb_data [$];

    always #5 clk_i = ~clk_i;

    softex_tcdm_splitter #(
        .MP(MP), .RESP_DEPTH(2), .ROW_BYTES(8), .IW(IW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i),
        .in_wen_i(in_wen_i), .in_be_i(in_be_i), .in_data_i(in_data_i),
        .in_id_i(in_id_i), .in_r_valid_o(in_r_valid_o), .in_r_ready_i(in_r_ready_i),
        .in_r_data_o(in_r_data_o), .in_r_id_o(in_r_id_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
        .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
        .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i)
    );

    function automatic logic [63:0] rw(input int id, input int p);
        return {16'hD0D0, 8'(id), 8'(p), 32'(id * 32'h01010101 + p * 32'h10)};
    endfunction

    function automatic logic [MP*64-1:0] wide(input int id);
        logic [MP*64-1:0] w;
        for (int p = 0; p < MP; p++) w[p*64 +: 64] = rw(id, p);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_gnt"},  256'(in_gnt_o),     0);
        chk({tag, "_r_valid"}, 256'(in_r_valid_o), 0);
        chk({tag, "_r_data"},  in_r_data_o,        0);
        chk({tag, "_r_id"},    256'(in_r_id_o),    0);
        chk({tag, "_req"},     256'(tcdm_req_o),   0);
        chk({tag, "_add"},     256'(tcdm_add_o),   0);
        chk({tag, "_wen"},     256'(tcdm_wen_o),   0);
        chk({tag, "_be"},      256'(tcdm_be_o),    0);
        chk({tag, "_data"},    tcdm_data_o,        0);
    endtask

    task automatic drive_read(input int id, input logic [31:0] add);
        in_req_i  = 1'b1;
        in_wen_i  = 1'b1;
        in_add_i  = add;
        in_id_i   = IW'(id);
        in_be_i   = '1;
        in_data_i = '0;
    endtask

    task automatic push_exp(input int id);
        sb_id.push_back(IW'(id));
        sb_data.push_back(wide(id));
    endtask

    // Scoreboard: every accepted wide response is checked against the oldest expectation
    always @(negedge clk_i) begin
        if (rst_ni && in_r_valid_o && in_r_ready_i) begin
            n_cmp++;
            assert (sb_id.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_rsp: observed id %0h expected no response", in_r_id_o);
            end
            if (sb_id.size() != 0) begin
                chk("rsp_id",   256'(in_r_id_o), 256'(sb_id.pop_front()));
                chk("rsp_data", in_r_data_o,     sb_data.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_ni         = 1'b0;
        in_req_i       = 1'b0;
        in_add_i       = 32'h1234_5678;
        in_wen_i       = 1'b1;
        in_be_i        = '1;
        in_data_i      = '1;
        in_id_i        = '0;
        in_r_ready_i   = 1'b0;
        tcdm_gnt_i     = '0;
        tcdm_r_valid_i = '0;
        tcdm_r_data_i  = '0;

        // reset: all outputs quiet while in_req_i is low, even with other inputs set
        #2;
        chk_zero("rst");
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        settle();
        chk_zero("post_rst");
        chk("post_rst_cnt", 256'(dut.cnt_q), 0);

        // single-cycle read, all ports granted together
        step();
        drive_read(5, 32'h0000_1000);
        tcdm_gnt_i = 4'hF;
        settle();
        chk("t1_add", 256'(tcdm_add_o), 256'({32'h1018, 32'h1010, 32'h1008, 32'h1000}));
        chk("t1_req", 256'(tcdm_req_o), 256'(4'hF));
        chk("t1_wen", 256'(tcdm_wen_o), 256'(4'hF));
        chk("t1_gnt", 256'(in_gnt_o), 1);
        push_exp(5);
        step();
        in_req_i   = 1'b0;
        tcdm_gnt_i = '0;
        chk("t1_cnt", 256'(dut.cnt_q), 1);

        // staggered grants: port 2 waits until cycle 3
        drive_read(6, 32'h0000_2000);
        tcdm_gnt_i = 4'b1011;
        settle();
        chk("t2_req_c0", 256'(tcdm_req_o), 256'(4'hF));
        chk("t2_gnt_c0", 256'(in_gnt_o), 0);
        step();
        tcdm_gnt_i = '0;
        settle();
        chk("t2_req_c1", 256'(tcdm_req_o), 256'(4'b0100));
        chk("t2_gnt_c1", 256'(in_gnt_o), 0);
        chk("t2_cnt_c1", 256'(dut.cnt_q), 2);
        step();
        settle();
        chk("t2_req_c2", 256'(tcdm_req_o), 256'(4'b0100));
        step();
        tcdm_gnt_i = 4'b0100;
        settle();
        chk("t2_req_c3", 256'(tcdm_req_o), 256'(4'b0100));
        chk("t2_gnt_c3", 256'(in_gnt_o), 1);
        chk("t2_add2",   256'(tcdm_add_o[95:64]), 256'(32'h2010));
        push_exp(6);
        step();
        in_req_i   = 1'b0;
        tcdm_gnt_i = '0;
        chk("t2_granted", 256'(dut.granted_q), 0);
        chk("t2_cnt",     256'(dut.cnt_q), 2);

        // responses: port 0 at t, ports 1-3 at t+2, wide valid at t+3
        tcdm_r_valid_i = 4'b0001;
        tcdm_r_data_i  = wide(5);
        step();
        tcdm_r_valid_i = '0;
        settle();
        chk("t3_valid_t1", 256'(in_r_valid_o), 0);
        step();
        tcdm_r_valid_i = 4'b1110;
        settle();
        chk("t3_valid_t2", 256'(in_r_valid_o), 0);
        step();
        tcdm_r_valid_i = '0;
        in_r_ready_i   = 1'b1;
        settle();
        chk("t3_valid_t3", 256'(in_r_valid_o), 1);
        chk("t3_id_t3",    256'(in_r_id_o), 5);
        step();
        tcdm_r_valid_i = 4'hF;
        tcdm_r_data_i  = wide(6);
        settle();
        chk("t3_valid_t4", 256'(in_r_valid_o), 0);
        step();
        tcdm_r_valid_i = '0;
        settle();
        chk("t3_valid_t5", 256'(in_r_valid_o), 1);
        step();
        in_r_ready_i = 1'b0;
        chk("t3_cnt",   256'(dut.cnt_q), 0);
        chk("t3_sb",    256'(sb_id.size()), 0);

        // credit limit: third read held off until the first wide pop
        drive_read(7, 32'h0000_5000);
        tcdm_gnt_i = 4'hF;
        settle();
        chk("t4_gnt7", 256'(in_gnt_o), 1);
        push_exp(7);
        step();
        drive_read(8, 32'h0000_5020);
        settle();
        chk("t4_gnt8", 256'(in_gnt_o), 1);
        push_exp(8);
        step();
        drive_read(9, 32'h0000_5040);
        settle();
        chk("t4_block_req", 256'(tcdm_req_o), 0);
        chk("t4_block_gnt", 256'(in_gnt_o), 0);
        chk("t4_cnt_full",  256'(dut.cnt_q), 2);
        step();
        settle();
        chk("t4_block_req2", 256'(tcdm_req_o), 0);
        step();
        tcdm_r_valid_i = 4'hF;
        tcdm_r_data_i  = wide(7);
        settle();
        chk("t4_block_req3", 256'(tcdm_req_o), 0);
        step();
        tcdm_r_valid_i = '0;
        in_r_ready_i   = 1'b1;
        settle();
        chk("t4_block_req4", 256'(tcdm_req_o), 0);
        step();
        in_r_ready_i = 1'b0;
        settle();
        chk("t4_issue_req", 256'(tcdm_req_o), 256'(4'hF));
        chk("t4_issue_gnt", 256'(in_gnt_o), 1);
        push_exp(9);
        step();
        in_req_i       = 1'b0;
        tcdm_gnt_i     = '0;
        tcdm_r_valid_i = 4'hF;
        tcdm_r_data_i  = wide(8);
        step();
        tcdm_r_data_i  = wide(9);
        step();
        tcdm_r_valid_i = '0;
        in_r_ready_i   = 1'b1;
        k = 0;
        while (sb_id.size() != 0 && k < 20) begin
            step();
            k++;
        end
        chk("t4_drain", 256'(sb_id.size()), 0);
        chk("t4_cnt",   256'(dut.cnt_q), 0);

        // write at the top of the address space: addresses wrap, no response
        in_req_i   = 1'b1;
        in_wen_i   = 1'b0;
        in_add_i   = 32'hFFFF_FFF8;
        in_id_i    = 8'h77;
        in_be_i    = 32'hF0F0_A5A5;
        in_data_i  = wide(99);
        tcdm_gnt_i = 4'hF;
        settle();
        chk("t5_add",  256'(tcdm_add_o), 256'({32'h10, 32'h08, 32'h00, 32'hFFFF_FFF8}));
        chk("t5_wen",  256'(tcdm_wen_o), 0);
        chk("t5_be",   256'(tcdm_be_o), 256'(32'hF0F0_A5A5));
        chk("t5_data", tcdm_data_o, wide(99));
        chk("t5_gnt",  256'(in_gnt_o), 1);
        step();
        in_req_i   = 1'b0;
        tcdm_gnt_i = '0;
        chk("t5_cnt", 256'(dut.cnt_q), 0);
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("t5_no_rsp", 256'(in_r_valid_o), 0);
            step();
        end

        // reset in the middle of a partially granted read
        drive_read(10, 32'h0000_3000);
        tcdm_gnt_i = 4'b0011;
        settle();
        chk("t6_req_c0", 256'(tcdm_req_o), 256'(4'hF));
        step();
        tcdm_gnt_i = '0;
        settle();
        chk("t6_granted", 256'(dut.granted_q), 256'(4'b0011));
        chk("t6_cnt",     256'(dut.cnt_q), 1);
        chk("t6_req_c1",  256'(tcdm_req_o), 256'(4'b1100));
        #2;
        rst_ni   = 1'b0;
        in_req_i = 1'b0;
        #1;
        chk("t6_rst_granted", 256'(dut.granted_q), 0);
        chk("t6_rst_cnt",     256'(dut.cnt_q), 0);
        chk_zero("t6_rst");
        step();
        step();
        rst_ni = 1'b1;
        settle();
        chk_zero("t6_after");

        // recovery: a fresh read after the abort completes normally
        step();
        drive_read(11, 32'h0000_4000);
        tcdm_gnt_i = 4'hF;
        settle();
        chk("t7_gnt", 256'(in_gnt_o), 1);
        push_exp(11);
        step();
        in_req_i       = 1'b0;
        tcdm_gnt_i     = '0;
        tcdm_r_valid_i = 4'hF;
        tcdm_r_data_i  = wide(11);
        step();
        tcdm_r_valid_i = '0;
        in_r_ready_i   = 1'b1;
        k = 0;
        while (sb_id.size() != 0 && k < 20) begin
            step();
            k++;
        end
        chk("t7_drain", 256'(sb_id.size()), 0);
        chk("t7_cnt",   256'(dut.cnt_q), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
